// File: rtl/vga_text_pkg.sv
// Shared geometry, fetch-phase and attribute-field constants for the text-mode sequencer.
package vga_text_pkg;
  localparam int COLS      = 80;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;

  localparam logic [2:0] PH_FETCH = 3'd0;
  localparam logic [2:0] PH_CHAR  = 3'd1;
  localparam logic [2:0] PH_GLYPH = 3'd2;
  localparam logic [2:0] PH_LOAD  = 3'(CHAR_W - 1);

  localparam int ATTR_FG_LSB  = 0;
  localparam int ATTR_BG_LSB  = 4;
  localparam int ATTR_FIELD_W = 4;
endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep raw syncs aligned with the pixel pipeline.
// Latency: DEPTH clocks. Backpressure: none, advances every clock.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= {DEPTH{RESET_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_text_sequencer.sv
// Text-mode pixel sequencer: text-RAM fetch, font lookup, 8-pixel serialiser, aligned syncs.
// Latency: 8 clocks from hCount/syncs to pixel/colour/sync outputs; CPU grant is combinational.
// Backpressure: none on video; a CPU request waits only during the display fetch slot.
module vga_text_sequencer #(
  parameter int   COLS      = vga_text_pkg::COLS,
  parameter int   H_VISIBLE = vga_text_pkg::H_VISIBLE,
  parameter int   V_VISIBLE = vga_text_pkg::V_VISIBLE,
  parameter int   ADDR_W    = 12,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic              hSyncIn,
  input  logic              vSyncIn,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramWe,
  output logic [15:0]       ramWData,
  input  logic [15:0]       ramRData,
  output logic [11:0]       fontAddr,
  input  logic [7:0]        fontData,
  input  logic              cpuReq,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [15:0]       cpuData,
  output logic              cpuAck,
  output logic              pixel,
  output logic [3:0]        fgIRGB,
  output logic [3:0]        bgIRGB,
  output logic              hSync,
  output logic              vSync
);
  import vga_text_pkg::*;

  localparam logic [9:0] H_LIM = 10'(H_VISIBLE);
  localparam logic [9:0] V_LIM = 10'(V_VISIBLE);

  logic [2:0] phase;
  logic [6:0] col;
  logic       fw;
  logic       display_slot;

  logic [7:0] char_q, char_d;
  logic [7:0] attr_q, attr_d;
  logic [7:0] glyph_q, glyph_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] fg_q, fg_d;
  logic [3:0] bg_q, bg_d;
  logic [1:0] sync_dly;

  always_comb begin
    phase        = hCount[2:0];
    col          = hCount[9:3];
    fw           = (hCount < H_LIM) && (vCount < V_LIM);
    display_slot = fw && (phase == PH_FETCH);

    cpuAck   = cpuReq && nReset && !display_slot;
    ramWe    = cpuAck;
    ramWData = cpuData;
    ramAddr  = display_slot ? ADDR_W'(vCount[9:4]) * ADDR_W'(COLS) + ADDR_W'(col) : cpuAddr;

    // The RAM word lands this cycle, so bypass the char register to hit the font ROM in time.
    fontAddr = {(phase == PH_CHAR) ? ramRData[7:0] : char_q, vCount[3:0]};
  end

  always_comb begin
    char_d  = char_q;
    attr_d  = attr_q;
    glyph_d = glyph_q;
    shift_d = {shift_q[6:0], 1'b0};
    fg_d    = fg_q;
    bg_d    = bg_q;
    if (fw && phase == PH_CHAR) begin
      {attr_d, char_d} = ramRData;
    end
    if (fw && phase == PH_GLYPH) begin
      glyph_d = fontData;
    end
    // Blanking is folded into the load so every output comes straight off a flop.
    if (phase == PH_LOAD) begin
      shift_d = fw ? glyph_q : 8'h00;
      fg_d    = fw ? attr_q[ATTR_FG_LSB +: ATTR_FIELD_W] : 4'h0;
      bg_d    = fw ? attr_q[ATTR_BG_LSB +: ATTR_FIELD_W] : 4'h0;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      char_q  <= '0;
      attr_q  <= '0;
      glyph_q <= '0;
      shift_q <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
    end else begin
      char_q  <= char_d;
      attr_q  <= attr_d;
      glyph_q <= glyph_d;
      shift_q <= shift_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
    end
  end

  vga_delay_line #(
    .WIDTH    (2),
    .DEPTH    (8),
    .RESET_VAL({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_dly (
    .clk  (clk),
    .rst_n(nReset),
    .din  ({vSyncIn, hSyncIn}),
    .dout (sync_dly)
  );

  assign pixel  = shift_q[7];
  assign fgIRGB = fg_q;
  assign bgIRGB = bg_q;
  assign hSync  = sync_dly[0];
  assign vSync  = sync_dly[1];
endmodule
